jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank_pkg.sv | 20 ++
 rtl/jk_ff_cell.sv | 38 +++
 rtl/jk_reg_bank.sv | 103 ++++++++++
 tb/tb_jk_reg_bank.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/jk_reg_bank_pkg.sv
// Shared definitions for the JK register bank: mode encodings and the
// characteristic equation of a single JK flip-flop.
package jk_reg_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_D   = 2'b01,
        MODE_T   = 2'b10,
        MODE_CNT = 2'b11
    } mode_e;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    // Q+ = J & ~Q | ~K & Q : hold, reset, set or toggle with no invalid state.
    function automatic logic jk_next(input logic j, input logic k, input logic q);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One edge-triggered JK flip-flop bit with synchronous active-low reset
// and a clock enable that holds the stored value.
module jk_ff_cell
    import jk_reg_bank_pkg::*;
(
    input  logic Clk,
    input  logic Rst_n,
    input  logic En,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_d;
    logic q_q;

    // Next-state selection: JK characteristic equation when enabled, else hold.
    always_comb begin
        q_d = q_q;
        if (En) begin
            q_d = jk_next(J, K, q_q);
        end else begin
            q_d = q_q;
        end
    end

    // State flop with synchronous reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops; the mode input maps D, T and counter behaviour
// onto per-cell J/K drives. Chg flags any bit change on the previous edge.
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             Chg,
    output logic             Tc
);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] cell_j_s;
    logic [WIDTH-1:0] cell_k_s;
    logic [WIDTH-1:0] q_next_s;
    logic             chg_d;
    logic             chg_q;

    // Ripple carry for counting: bit i toggles only when all lower bits are 1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        if (i == 0) begin : g_lsb
            assign carry_s[i] = 1'b1;
        end else begin : g_upper
            assign carry_s[i] = &q_s[i-1:0];
        end
    end

    // Mode to per-cell J/K mapping.
    always_comb begin
        cell_j_s = '0;
        cell_k_s = '0;
        case (Mode)
            MODE_JK: begin
                cell_j_s = J;
                cell_k_s = K;
            end
            MODE_D: begin
                cell_j_s = J;
                cell_k_s = ~J;
            end
            MODE_T: begin
                cell_j_s = J;
                cell_k_s = J;
            end
            MODE_CNT: begin
                cell_j_s = carry_s;
                cell_k_s = carry_s;
            end
            default: begin
                cell_j_s = '0;
                cell_k_s = '0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .Clk   (Clk),
            .Rst_n (Rst_n),
            .En    (En),
            .J     (cell_j_s[i]),
            .K     (cell_k_s[i]),
            .Q     (q_s[i])
        );
    end

    // Mirror of the cells' next state, used only to detect a change.
    always_comb begin
        q_next_s = q_s;
        for (int i = 0; i < WIDTH; i++) begin
            if (En) begin
                q_next_s[i] = jk_next(cell_j_s[i], cell_k_s[i], q_s[i]);
            end else begin
                q_next_s[i] = q_s[i];
            end
        end
        chg_d = (q_next_s != q_s);
    end

    // Change flag register, cleared by reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign Q   = q_s;
    assign Qn  = ~q_s;
    assign Chg = chg_q;
    assign Tc  = En & (Mode == MODE_CNT) & (&q_s);

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: directed steps push expected post-edge
// state; monitors pop and compare on the falling edge.
module tb_jk_reg_bank;
    import jk_reg_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] j = 8'h00, k = 8'h00;
    logic [7:0] q, qn;
    logic       chg, tc;

    logic       rst1_n = 1'b0, en1 = 1'b0;
    logic [1:0] mode1 = 2'b00;
    logic [0:0] j1 = 1'b0, k1 = 1'b0;
    logic [0:0] q1, qn1;
    logic       chg1, tc1;

    jk_reg_bank #(.WIDTH(8)) dut8 (
        .Clk(clk), .Rst_n(rst_n), .En(en), .Mode(mode), .J(j), .K(k),
        .Q(q), .Qn(qn), .Chg(chg), .Tc(tc)
    );

    jk_reg_bank #(.WIDTH(1)) dut1 (
        .Clk(clk), .Rst_n(rst1_n), .En(en1), .Mode(mode1), .J(j1), .K(k1),
        .Q(q1), .Qn(qn1), .Chg(chg1), .Tc(tc1)
    );

    typedef struct {
        logic [7:0] q;
        logic       chg;
        logic       tc;
        string      name;
    } exp_t;

    exp_t sb8[$];
    exp_t sb1[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input string what,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h, expected %h", name, what, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb8.size() > 0) begin
            e = sb8.pop_front();
            check(e.name, "Q",   q,            e.q);
            check(e.name, "Qn",  qn,           ~e.q);
            check(e.name, "Chg", {7'd0, chg},  {7'd0, e.chg});
            check(e.name, "Tc",  {7'd0, tc},   {7'd0, e.tc});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            check(e.name, "Q",   {7'd0, q1},   {7'd0, e.q[0]});
            check(e.name, "Qn",  {7'd0, qn1},  {7'd0, ~e.q[0]});
            check(e.name, "Chg", {7'd0, chg1}, {7'd0, e.chg});
            check(e.name, "Tc",  {7'd0, tc1},  {7'd0, e.tc});
        end
    end

    task automatic step8(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] jv, input logic [7:0] kv,
                         input logic [7:0] eq, input logic ec, input logic et,
                         input string nm);
        @(negedge clk);
        #1;
        rst_n = r; en = e; mode = m; j = jv; k = kv;
        sb8.push_back('{q: eq, chg: ec, tc: et, name: nm});
        @(posedge clk);
    endtask

    task automatic step1(input logic r, input logic e, input logic [1:0] m,
                         input logic eq, input logic ec, input logic et,
                         input string nm);
        @(negedge clk);
        #1;
        rst1_n = r; en1 = e; mode1 = m; j1 = 1'b0; k1 = 1'b0;
        sb1.push_back('{q: {7'd0, eq}, chg: ec, tc: et, name: nm});
        @(posedge clk);
    endtask

    task automatic drain(input int which);
        for (int c = 0; c < 10 && ((which == 8) ? sb8.size() : sb1.size()) > 0; c++)
            @(posedge clk);
        n_checks++;
        if (((which == 8) ? sb8.size() : sb1.size()) != 0) begin
            n_fail++;
            $display("FAIL drain%0d: scoreboard not empty, got %0d entries, expected 0",
                     which, (which == 8) ? sb8.size() : sb1.size());
        end
    endtask

    initial begin
        // reset held two edges, then released with the same inputs
        step8(1'b0, 1'b1, MODE_JK,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, "rst0");
        step8(1'b0, 1'b1, MODE_JK,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, "rst1");
        step8(1'b1, 1'b1, MODE_JK,  8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, "rel");
        // JK truth table
        step8(1'b1, 1'b1, MODE_D,   8'h0F, 8'h00, 8'h0F, 1'b1, 1'b0, "ld0F");
        step8(1'b1, 1'b1, MODE_JK,  8'hF0, 8'h0F, 8'hF0, 1'b1, 1'b0, "jk_setrst");
        step8(1'b1, 1'b1, MODE_JK,  8'hFF, 8'hFF, 8'h0F, 1'b1, 1'b0, "jk_tog");
        step8(1'b1, 1'b1, MODE_JK,  8'h00, 8'h00, 8'h0F, 1'b0, 1'b0, "jk_hold");
        // D, T, disabled hold
        step8(1'b1, 1'b1, MODE_D,   8'hA5, 8'h5A, 8'hA5, 1'b1, 1'b0, "d_A5");
        step8(1'b1, 1'b1, MODE_T,   8'h0F, 8'hFF, 8'hAA, 1'b1, 1'b0, "t_0F");
        step8(1'b1, 1'b0, MODE_T,   8'hFF, 8'hFF, 8'hAA, 1'b0, 1'b0, "en0");
        // count and wrap
        step8(1'b1, 1'b1, MODE_D,   8'hFD, 8'h00, 8'hFD, 1'b1, 1'b0, "ldFD");
        step8(1'b1, 1'b1, MODE_CNT, 8'h00, 8'hFF, 8'hFE, 1'b1, 1'b0, "cntFE");
        step8(1'b1, 1'b1, MODE_CNT, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, "cntFF");
        step8(1'b1, 1'b1, MODE_CNT, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, "wrap");
        // reset mid-count
        step8(1'b1, 1'b1, MODE_D,   8'h37, 8'h00, 8'h37, 1'b1, 1'b0, "ld37");
        step8(1'b0, 1'b1, MODE_CNT, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "rstcnt");
        step8(1'b1, 1'b1, MODE_CNT, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, "cnt01");
        step8(1'b1, 1'b1, MODE_CNT, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, "cnt02");
        // Tc gated by En and mode; mode change carries Q over
        step8(1'b1, 1'b1, MODE_D,   8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, "ldFF");
        step8(1'b1, 1'b0, MODE_CNT, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, "cnt_en0");
        step8(1'b1, 1'b1, MODE_CNT, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, "cnt_wrap2");
        // reset wins over En=0
        step8(1'b1, 1'b1, MODE_D,   8'h55, 8'h00, 8'h55, 1'b1, 1'b0, "ld55");
        step8(1'b0, 1'b0, MODE_T,   8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "rst_en0");
        drain(8);

        // single-channel counter
        step1(1'b0, 1'b1, MODE_CNT, 1'b0, 1'b0, 1'b0, "w1_rst");
        step1(1'b1, 1'b1, MODE_CNT, 1'b1, 1'b1, 1'b1, "w1_c1");
        step1(1'b1, 1'b1, MODE_CNT, 1'b0, 1'b1, 1'b0, "w1_c2");
        step1(1'b1, 1'b1, MODE_CNT, 1'b1, 1'b1, 1'b1, "w1_c3");
        step1(1'b1, 1'b1, MODE_CNT, 1'b0, 1'b1, 1'b0, "w1_c4");
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
